// File: rtl/mem_port_arbiter.sv
// Two-requester req/ack arbiter sharing one unified instruction/data memory port.
// Build option ARB_FIXED_PRIO_EN: ties always go to port 0 (default build: round-robin).
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic          grant_valid_s;
    logic          grant_port_s;
    logic          owner_r;
    logic          we_r;
    logic          busy_r;
    logic          mem_we_r;
    logic          m0_ack_r;
    logic          m1_ack_r;
    logic [2:0]    cnt_r;
    logic [AW-1:0] mem_adr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [DW-1:0] m0_rdata_r;
    logic [DW-1:0] m1_rdata_r;
`ifndef ARB_FIXED_PRIO_EN
    logic          last_grant_r;
`endif

    // Winner among the requests presented while idle
    always_comb begin
        grant_valid_s = m0_req | m1_req;
        grant_port_s  = 1'b0;
        if (m0_req && m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
            grant_port_s = 1'b0;
`else
            grant_port_s = ~last_grant_r;
`endif
        end else if (m1_req) begin
            grant_port_s = 1'b1;
        end else begin
            grant_port_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) next_state_s = ISSUE;
                else               next_state_s = IDLE;
            end
            ISSUE: begin
                if (we_r) next_state_s = ACK;
                else      next_state_s = WAIT;
            end
            WAIT: begin
                if (cnt_r == 3'd1) next_state_s = ACK;
                else               next_state_s = WAIT;
            end
            ACK:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register and status/handshake outputs, registered off the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            m0_ack_r <= 1'b0;
            m1_ack_r <= 1'b0;
            cnt_r    <= 3'd0;
        end else begin
            state_r  <= next_state_s;
            busy_r   <= (next_state_s != IDLE);
            m0_ack_r <= (next_state_s == ACK) && !owner_r;
            m1_ack_r <= (next_state_s == ACK) && owner_r;
            if (state_r == ISSUE) begin
                cnt_r <= 3'(RD_LAT);
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - 3'd1;
            end
        end
    end

    // Grant capture, memory-side drive and read-data return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_r     <= 1'b0;
            we_r        <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_adr_r   <= '0;
            mem_wdata_r <= '0;
            m0_rdata_r  <= '0;
            m1_rdata_r  <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_r <= 1'b1;
`endif
        end else begin
            mem_we_r <= 1'b0;
            if (state_r == IDLE && grant_valid_s) begin
                owner_r <= grant_port_s;
`ifndef ARB_FIXED_PRIO_EN
                last_grant_r <= grant_port_s;
`endif
                // Address/data go straight to the memory-side registers so they hold afterwards
                if (grant_port_s) begin
                    we_r        <= m1_we;
                    mem_we_r    <= m1_we;
                    mem_adr_r   <= m1_adr;
                    mem_wdata_r <= m1_wdata;
                end else begin
                    we_r        <= m0_we;
                    mem_we_r    <= m0_we;
                    mem_adr_r   <= m0_adr;
                    mem_wdata_r <= m0_wdata;
                end
            end
            if (state_r == WAIT && cnt_r == 3'd1) begin
                if (owner_r) m1_rdata_r <= mem_rdata;
                else         m0_rdata_r <= mem_rdata;
            end
        end
    end

    assign m0_ack    = m0_ack_r;
    assign m1_ack    = m1_ack_r;
    assign m0_rdata  = m0_rdata_r;
    assign m1_rdata  = m1_rdata_r;
    assign mem_adr   = mem_adr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a cycle-count reference model predicts grants,
// acks, memory strobes and read data; a negedge monitor compares everything the DUT shows.
module tb_mem_port_arbiter;

    localparam int RD_LAT = 2;

    typedef struct {
        int          ackc;
        logic        we;
        logic [31:0] rdata;
    } ack_t;

    typedef struct {
        int          c;
        logic [31:0] adr;
        logic [31:0] wd;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_adr = 32'h0, m0_wdata = 32'h0, m1_adr = 32'h0, m1_wdata = 32'h0;
    logic        m0_ack, m1_ack, mem_we, busy, owner;
    logic [31:0] m0_rdata, m1_rdata, mem_adr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] mem_arr [64];
    logic [31:0] ref_mem [64];
    ack_t        q0 [$];
    ack_t        q1 [$];
    wr_t         qw [$];
    bit          ack_order [$];

    int          free_cyc = 0, busy_from = 0, busy_to = -1, rd_issue = -100;
    logic        exp_owner = 1'b0, last_g = 1'b1;
    logic [31:0] hold0 = 32'h0, hold1 = 32'h0, rd_adr_seen = 32'h0;

    logic        mp, mwe;
    logic [31:0] madr, mwd;
    ack_t        mdl_a, mon_a;
    wr_t         mdl_w, mon_w;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int p, input logic we, input logic [31:0] adr, input logic [31:0] wd);
        if (p == 0) begin m0_req = 1'b1; m0_we = we; m0_adr = adr; m0_wdata = wd; end
        else        begin m1_req = 1'b1; m1_we = we; m1_adr = adr; m1_wdata = wd; end
    endtask

    task automatic rel(input int p);
        if (p == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    // Waits (bounded) for the port's ack, then returns at the start of the following cycle
    task automatic wait_ack(input int p);
        logic got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? m0_ack : m1_ack;
        end
        if (!got) check((p == 0) ? "ack0_timeout" : "ack1_timeout",
                        64'((p == 0) ? m0_ack : m1_ack), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        rel(0);
        rel(1);
        q0.delete(); q1.delete(); qw.delete();
        hold0 = 32'h0; hold1 = 32'h0; last_g = 1'b1; free_cyc = 0;
        busy_to = -1; exp_owner = 1'b0; rd_issue = -100;
        #1;
        check("rst_m0_ack", 64'(m0_ack), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_m0_rdata", 64'(m0_rdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic rand_port(input int p);
        int gap;
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                rel(p);
                repeat (gap) @(posedge clk);
                #1;
            end
            drive(p, 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 33)), 2'b00}, $urandom);
            wait_ack(p);
        end
        rel(p);
    endtask

    // Reference model: one transaction at a time, grant when free, fixed cycle costs
    initial begin
        forever begin
            @(posedge clk);
            if (!reset && cyc >= free_cyc && (m0_req || m1_req)) begin
                if (m0_req && m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
                    mp = 1'b0;
`else
                    mp = ~last_g;
`endif
                end else begin
                    mp = m1_req;
                end
                last_g = mp;
                mwe  = mp ? m1_we : m0_we;
                madr = mp ? m1_adr : m0_adr;
                mwd  = mp ? m1_wdata : m0_wdata;
                mdl_a.ackc  = mwe ? cyc + 2 : cyc + 2 + RD_LAT;
                mdl_a.we    = mwe;
                mdl_a.rdata = mwe ? 32'h0 : ref_mem[madr[7:2]];
                if (mwe) begin
                    ref_mem[madr[7:2]] = mwd;
                    mdl_w.c = cyc + 1; mdl_w.adr = madr; mdl_w.wd = mwd;
                    qw.push_back(mdl_w);
                end else begin
                    rd_issue = cyc + 1;
                end
                if (mp) q1.push_back(mdl_a);
                else    q0.push_back(mdl_a);
                busy_from = cyc + 1;
                busy_to   = mdl_a.ackc;
                exp_owner = mp;
                free_cyc  = mdl_a.ackc + 1;
            end
            cyc++;
            #1;
            // Memory returns data only in the cycle RD_LAT after a read issue; junk otherwise
            mem_rdata = (cyc - RD_LAT == rd_issue) ? mem_arr[rd_adr_seen[7:2]] : (32'hBAD0_0000 ^ 32'(cyc));
        end
    end

    // Monitor: pops expectations whenever the DUT strobes memory or acks a port
    initial begin
        forever begin
            @(negedge clk);
            if (mem_we) begin
                if (qw.size() == 0) begin
                    check("mem_we_unexpected", 64'(mem_we), 64'd0);
                end else begin
                    mon_w = qw.pop_front();
                    check("mem_we_cycle", 64'(cyc), 64'(mon_w.c));
                    check("mem_we_adr", 64'(mem_adr), 64'(mon_w.adr));
                    check("mem_we_wdata", 64'(mem_wdata), 64'(mon_w.wd));
                end
                mem_arr[mem_adr[7:2]] = mem_wdata;
            end else if (qw.size() > 0 && qw[0].c <= cyc) begin
                mon_w = qw.pop_front();
                check("mem_we_missing", 64'(mem_we), 64'd1);
            end
            if (cyc == rd_issue) rd_adr_seen = mem_adr;

            if (m0_ack) begin
                ack_order.push_back(1'b0);
                if (q0.size() == 0) begin
                    check("ack0_unexpected", 64'(m0_ack), 64'd0);
                end else begin
                    mon_a = q0.pop_front();
                    check("ack0_cycle", 64'(cyc), 64'(mon_a.ackc));
                    if (!mon_a.we) begin
                        check("ack0_rdata", 64'(m0_rdata), 64'(mon_a.rdata));
                        hold0 = mon_a.rdata;
                    end
                end
            end else if (q0.size() > 0 && q0[0].ackc <= cyc) begin
                mon_a = q0.pop_front();
                check("ack0_missing", 64'(m0_ack), 64'd1);
            end

            if (m1_ack) begin
                ack_order.push_back(1'b1);
                if (q1.size() == 0) begin
                    check("ack1_unexpected", 64'(m1_ack), 64'd0);
                end else begin
                    mon_a = q1.pop_front();
                    check("ack1_cycle", 64'(cyc), 64'(mon_a.ackc));
                    if (!mon_a.we) begin
                        check("ack1_rdata", 64'(m1_rdata), 64'(mon_a.rdata));
                        hold1 = mon_a.rdata;
                    end
                end
            end else if (q1.size() > 0 && q1[0].ackc <= cyc) begin
                mon_a = q1.pop_front();
                check("ack1_missing", 64'(m1_ack), 64'd1);
            end

            check("rdata0_hold", 64'(m0_rdata), 64'(hold0));
            check("rdata1_hold", 64'(m1_rdata), 64'(hold1));
            check("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
            check("owner", 64'(owner), 64'(exp_owner));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_order [6];
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end
        mem_arr[32] = 32'hCAFE_F00D;
        ref_mem[32] = 32'hCAFE_F00D;
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_adr", 64'(mem_adr), 64'd0);
        check("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        check("reset_mem_we", 64'(mem_we), 64'd0);
        check("reset_acks", 64'({m0_ack, m1_ack}), 64'd0);
        check("reset_rdata", 64'({m0_rdata, m1_rdata}), 64'd0);
        check("reset_busy_owner", 64'({busy, owner}), 64'd0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Port 0 write, then port 1 read of the preloaded word
        drive(0, 1'b1, 32'h40, 32'h1234_5678);
        wait_ack(0);
        rel(0);
        check("t1_mem_written", 64'(mem_arr[16]), 64'h1234_5678);
        drive(1, 1'b0, 32'h80, 32'h0);
        wait_ack(1);
        rel(1);
        check("t2_m1_rdata", 64'(m1_rdata), 64'hCAFE_F00D);
        check("t2_m0_rdata", 64'(m0_rdata), 64'd0);

        // Simultaneous reads from both ports, each re-requesting back-to-back
        @(posedge clk);
        #3;
        assert_reset();
        @(posedge clk);
        #1;
        ack_order.delete();
        drive(0, 1'b0, 32'h04, 32'h0);
        drive(1, 1'b0, 32'h08, 32'h0);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_ack(0);
                    if (k < 2) drive(0, 1'b0, 32'h0C + 32'(k) * 32'h4, 32'h0);
                    else       rel(0);
                end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_ack(1);
                    if (k < 2) drive(1, 1'b0, 32'h20 + 32'(k) * 32'h4, 32'h0);
                    else       rel(1);
                end
            end
        join
        check("t3_order_len", 64'(ack_order.size()), 64'd6);
        for (int i = 0; i < 6; i++) check("t3_grant_order", 64'(ack_order[i]), 64'(exp_order[i]));

        // Port 1 arrives while a port 0 read is waiting on memory
        drive(0, 1'b0, 32'h10, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        drive(1, 1'b1, 32'h24, 32'hA5A5_0001);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t4_adr_hold", 64'(mem_adr), 64'h10);
            if (m0_ack) break;
        end
        @(posedge clk);
        #1;
        rel(0);
        wait_ack(1);
        rel(1);
        check("t4_m1_write", 64'(mem_arr[9]), 64'hA5A5_0001);

        // Reset during the WAIT phase of a port 0 read
        check("t5_pre_rdata", 64'(m0_rdata != 32'h0), 64'd1);
        drive(0, 1'b0, 32'h14, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_pre_busy", 64'(busy), 64'd1);
        #2;
        assert_reset();
        @(posedge clk);
        #1;
        drive(1, 1'b1, 32'h84, 32'h5EED_1234);
        wait_ack(1);
        rel(1);
        check("t5_post_write", 64'(mem_arr[33]), 64'h5EED_1234);

        // Randomized traffic from both ports
        fork
            rand_port(0);
            rand_port(1);
        join

        repeat (10) @(posedge clk);
        #1;
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("qw_drained", 64'(qw.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
